// File: rtl/gcn_pkg.sv
// Shared dimensions, state encoding and element type for the GCN matrix memory server.
package gcn_pkg;

  localparam int unsigned FEATURE_ROWS    = 6;
  localparam int unsigned FEATURE_COLS    = 96;
  localparam int unsigned WEIGHT_ROWS     = 96;
  localparam int unsigned WEIGHT_COLS     = 3;
  localparam int unsigned ELEM_WIDTH      = 5;
  localparam int unsigned ADDRESS_WIDTH   = 13;
  localparam int unsigned FEATURE_BASE    = 512;
  localparam int unsigned COO_NUM_OF_COLS = 6;
  localparam int unsigned COO_BW          = $clog2(COO_NUM_OF_COLS);

  typedef enum logic [1:0] {LOAD_W, LOAD_F, LOAD_C, SERVE} mem_state_t;

  typedef logic [ELEM_WIDTH-1:0] elem_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gcn_load_ctrl.sv
// Load sequencer: walks weight, feature and COO streams, producing write strobes and
// the row/column indices for each accepted element.
module gcn_load_ctrl #(
  parameter int unsigned WEIGHT_ROWS     = gcn_pkg::WEIGHT_ROWS,
  parameter int unsigned WEIGHT_COLS     = gcn_pkg::WEIGHT_COLS,
  parameter int unsigned FEATURE_ROWS    = gcn_pkg::FEATURE_ROWS,
  parameter int unsigned FEATURE_COLS    = gcn_pkg::FEATURE_COLS,
  parameter int unsigned COO_NUM_OF_COLS = gcn_pkg::COO_NUM_OF_COLS,
  parameter int unsigned COO_BW          = gcn_pkg::COO_BW,
  parameter int unsigned INNER_W         = 7,
  parameter int unsigned OUTER_W         = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_valid,
  input  logic               i_reload,
  output logic               o_load_ready,
  output logic               o_mem_ready,
  output logic               o_w_we,
  output logic               o_f_we,
  output logic               o_coo_row_we,
  output logic               o_coo_col_we,
  output logic [OUTER_W-1:0] o_outer,
  output logic [INNER_W-1:0] o_inner,
  output logic [COO_BW-1:0]  o_coo_idx
);
  import gcn_pkg::*;

  localparam logic [INNER_W-1:0] WInnerLast = INNER_W'(WEIGHT_ROWS - 1);
  localparam logic [INNER_W-1:0] FInnerLast = INNER_W'(FEATURE_COLS - 1);
  localparam logic [INNER_W-1:0] CInnerLast = INNER_W'(2 * COO_NUM_OF_COLS - 1);
  localparam logic [INNER_W-1:0] CooN       = INNER_W'(COO_NUM_OF_COLS);
  localparam logic [OUTER_W-1:0] WOuterLast = OUTER_W'(WEIGHT_COLS - 1);
  localparam logic [OUTER_W-1:0] FOuterLast = OUTER_W'(FEATURE_ROWS - 1);

  mem_state_t         r_state, w_state_next, w_state_succ;
  logic [INNER_W-1:0] r_inner, w_inner_next;
  logic [OUTER_W-1:0] r_outer, w_outer_next;
  logic               r_load_ready, r_mem_ready;
  logic               w_xfer, w_inner_last, w_outer_last;

  always_comb begin
    w_state_next = r_state;
    w_state_succ = r_state;
    w_inner_next = r_inner;
    w_outer_next = r_outer;
    w_inner_last = 1'b0;
    w_outer_last = 1'b1;
    o_w_we       = 1'b0;
    o_f_we       = 1'b0;
    o_coo_row_we = 1'b0;
    o_coo_col_we = 1'b0;
    // A reload in the same cycle discards the element on the bus.
    w_xfer       = i_load_valid && r_load_ready && !i_reload;

    case (r_state)
      LOAD_W: begin
        w_inner_last = (r_inner == WInnerLast);
        w_outer_last = (r_outer == WOuterLast);
        w_state_succ = LOAD_F;
        o_w_we       = w_xfer;
      end
      LOAD_F: begin
        w_inner_last = (r_inner == FInnerLast);
        w_outer_last = (r_outer == FOuterLast);
        w_state_succ = LOAD_C;
        o_f_we       = w_xfer;
      end
      LOAD_C: begin
        w_inner_last = (r_inner == CInnerLast);
        w_state_succ = SERVE;
        o_coo_row_we = w_xfer && (r_inner < CooN);
        o_coo_col_we = w_xfer && !(r_inner < CooN);
      end
      default: ;
    endcase

    if (i_reload) begin
      w_state_next = LOAD_W;
      w_inner_next = '0;
      w_outer_next = '0;
    end else if (w_xfer) begin
      if (w_inner_last) begin
        w_inner_next = '0;
        if (w_outer_last) begin
          w_outer_next = '0;
          w_state_next = w_state_succ;
        end else begin
          w_outer_next = r_outer + 1'b1;
        end
      end else begin
        w_inner_next = r_inner + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= LOAD_W;
      r_inner      <= '0;
      r_outer      <= '0;
      r_load_ready <= 1'b0;
      r_mem_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_inner      <= w_inner_next;
      r_outer      <= w_outer_next;
      r_load_ready <= (w_state_next != SERVE);
      r_mem_ready  <= (w_state_next == SERVE);
    end
  end

  assign o_load_ready = r_load_ready;
  assign o_mem_ready  = r_mem_ready;
  assign o_outer      = r_outer;
  assign o_inner      = r_inner;
  // COO entries 0..N-1 are rows, N..2N-1 are columns.
  assign o_coo_idx    = COO_BW'((r_inner < CooN) ? r_inner : r_inner - CooN);

endmodule

// File: rtl/gcn_matrix_mem_server.sv
// Weight/feature/COO memory serving one row vector per read for the GCN datapath.
// Optional MEM_RANGE_CHECK_EN adds the o_addr_error output.
module gcn_matrix_mem_server #(
  parameter int unsigned FEATURE_ROWS    = gcn_pkg::FEATURE_ROWS,
  parameter int unsigned FEATURE_COLS    = gcn_pkg::FEATURE_COLS,
  parameter int unsigned WEIGHT_ROWS     = gcn_pkg::WEIGHT_ROWS,
  parameter int unsigned WEIGHT_COLS     = gcn_pkg::WEIGHT_COLS,
  parameter int unsigned ELEM_WIDTH      = gcn_pkg::ELEM_WIDTH,
  parameter int unsigned ADDRESS_WIDTH   = gcn_pkg::ADDRESS_WIDTH,
  parameter int unsigned FEATURE_BASE    = gcn_pkg::FEATURE_BASE,
  parameter int unsigned COO_NUM_OF_COLS = gcn_pkg::COO_NUM_OF_COLS,
  parameter int unsigned COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_load_valid,
  output logic                     o_load_ready,
  input  logic [ELEM_WIDTH-1:0]    i_load_data,
  input  logic                     i_reload,
  output logic                     o_mem_ready,
  input  logic                     i_enable_read,
  input  logic [ADDRESS_WIDTH-1:0] i_read_address,
  output logic [ELEM_WIDTH-1:0]    o_data_out [WEIGHT_ROWS],
  output logic                     o_data_valid,
  input  logic [COO_BW-1:0]        i_coo_address,
`ifdef MEM_RANGE_CHECK_EN
  output logic [2*COO_BW-1:0]      o_coo_out,
  output logic                     o_addr_error
`else
  output logic [2*COO_BW-1:0]      o_coo_out
`endif
);
  import gcn_pkg::*;

  localparam int unsigned InnerW =
    $clog2(max_u(max_u(WEIGHT_ROWS, FEATURE_COLS), 2 * COO_NUM_OF_COLS));
  localparam int unsigned OuterW = $clog2(max_u(WEIGHT_COLS, FEATURE_ROWS));
  localparam int unsigned WcW    = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int unsigned FrW    = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;

  logic [ELEM_WIDTH-1:0] r_weight  [WEIGHT_COLS][WEIGHT_ROWS];
  logic [ELEM_WIDTH-1:0] r_feature [FEATURE_ROWS][FEATURE_COLS];
  logic [COO_BW-1:0]     r_coo_row [COO_NUM_OF_COLS];
  logic [COO_BW-1:0]     r_coo_col [COO_NUM_OF_COLS];
  logic [ELEM_WIDTH-1:0] r_data_out [WEIGHT_ROWS];
  logic [ELEM_WIDTH-1:0] w_rd_vec   [WEIGHT_ROWS];
  logic                  r_data_valid;

  logic                     w_w_we, w_f_we, w_coo_row_we, w_coo_col_we, w_serve;
  logic [OuterW-1:0]        w_outer;
  logic [InnerW-1:0]        w_inner;
  logic [COO_BW-1:0]        w_coo_idx;
  logic [ADDRESS_WIDTH-1:0] w_feat_off;
  logic                     w_is_feat, w_in_range, w_rd_fire;

  gcn_load_ctrl #(
    .WEIGHT_ROWS    (WEIGHT_ROWS),
    .WEIGHT_COLS    (WEIGHT_COLS),
    .FEATURE_ROWS   (FEATURE_ROWS),
    .FEATURE_COLS   (FEATURE_COLS),
    .COO_NUM_OF_COLS(COO_NUM_OF_COLS),
    .COO_BW         (COO_BW),
    .INNER_W        (InnerW),
    .OUTER_W        (OuterW)
  ) u_load_ctrl (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load_valid(i_load_valid),
    .i_reload    (i_reload),
    .o_load_ready(o_load_ready),
    .o_mem_ready (w_serve),
    .o_w_we      (w_w_we),
    .o_f_we      (w_f_we),
    .o_coo_row_we(w_coo_row_we),
    .o_coo_col_we(w_coo_col_we),
    .o_outer     (w_outer),
    .o_inner     (w_inner),
    .o_coo_idx   (w_coo_idx)
  );

  assign o_mem_ready = w_serve;

  // Storage is deliberately not reset; contents are only valid once o_mem_ready is high.
  always_ff @(posedge i_clk) begin
    if (w_w_we)       r_weight[w_outer[WcW-1:0]][w_inner]  <= i_load_data;
    if (w_f_we)       r_feature[w_outer[FrW-1:0]][w_inner] <= i_load_data;
    if (w_coo_row_we) r_coo_row[w_coo_idx] <= i_load_data[COO_BW-1:0];
    if (w_coo_col_we) r_coo_col[w_coo_idx] <= i_load_data[COO_BW-1:0];
  end

  always_comb begin
    w_feat_off = i_read_address - ADDRESS_WIDTH'(FEATURE_BASE);
    w_is_feat  = (i_read_address >= ADDRESS_WIDTH'(FEATURE_BASE));
    w_in_range = w_is_feat ? (w_feat_off < ADDRESS_WIDTH'(FEATURE_ROWS))
                           : (i_read_address < ADDRESS_WIDTH'(WEIGHT_COLS));
    w_rd_vec   = '{default: '0};
    if (w_in_range) begin
      if (w_is_feat) w_rd_vec = r_feature[w_feat_off[FrW-1:0]];
      else           w_rd_vec = r_weight[i_read_address[WcW-1:0]];
    end
  end

  assign w_rd_fire = i_enable_read && w_serve && !i_reload;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_valid <= 1'b0;
      r_data_out   <= '{default: '0};
    end else begin
      r_data_valid <= w_rd_fire;
      if (w_rd_fire) r_data_out <= w_rd_vec;
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;

`ifdef MEM_RANGE_CHECK_EN
  logic r_addr_error;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_addr_error <= 1'b0;
    else         r_addr_error <= i_enable_read && !i_reload && (!w_serve || !w_in_range);
  end

  assign o_addr_error = r_addr_error;
`endif

  always_comb begin
    o_coo_out = '0;
    if (i_coo_address < COO_BW'(COO_NUM_OF_COLS)) begin
      o_coo_out = {r_coo_row[i_coo_address], r_coo_col[i_coo_address]};
    end
  end

endmodule

// File: tb/tb_gcn_matrix_mem_server.sv
// Self-checking bench for gcn_matrix_mem_server: load sequence, reads via scoreboard,
// COO sweep, reset mid-load and reload-vs-read priority.
module tb_gcn_matrix_mem_server;
  import gcn_pkg::*;

  localparam int unsigned VEC_W = ELEM_WIDTH * WEIGHT_ROWS;
  localparam int NTOT = WEIGHT_COLS * WEIGHT_ROWS + FEATURE_ROWS * FEATURE_COLS
                        + 2 * COO_NUM_OF_COLS;

  logic                     clk = 1'b0;
  logic                     i_reset, i_load_valid, i_reload, i_enable_read;
  logic [ELEM_WIDTH-1:0]    i_load_data;
  logic [ADDRESS_WIDTH-1:0] i_read_address;
  logic [COO_BW-1:0]        i_coo_address;
  logic                     o_load_ready, o_mem_ready, o_data_valid;
  logic [ELEM_WIDTH-1:0]    o_data_out [WEIGHT_ROWS];
  logic [2*COO_BW-1:0]      o_coo_out;
`ifdef MEM_RANGE_CHECK_EN
  logic                     o_addr_error;
`endif

  gcn_matrix_mem_server u_dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_load_valid  (i_load_valid),
    .o_load_ready  (o_load_ready),
    .i_load_data   (i_load_data),
    .i_reload      (i_reload),
    .o_mem_ready   (o_mem_ready),
    .i_enable_read (i_enable_read),
    .i_read_address(i_read_address),
    .o_data_out    (o_data_out),
    .o_data_valid  (o_data_valid),
    .i_coo_address (i_coo_address),
`ifdef MEM_RANGE_CHECK_EN
    .o_coo_out     (o_coo_out),
    .o_addr_error  (o_addr_error)
`else
    .o_coo_out     (o_coo_out)
`endif
  );

  always #5 clk = ~clk;

  logic [VEC_W-1:0] dut_flat;
  always_comb begin
    dut_flat = '0;
    for (int i = 0; i < int'(WEIGHT_ROWS); i++) dut_flat[i*ELEM_WIDTH +: ELEM_WIDTH] = o_data_out[i];
  end

  typedef struct {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ELEM_WIDTH-1:0]    d0;
    logic [ELEM_WIDTH-1:0]    d95;
    logic                     err;
  } rd_rec_t;

  rd_rec_t           tbl [9];
  logic [VEC_W-1:0]  sb_q [$];
  logic [VEC_W-1:0]  last_exp;
  logic [COO_BW-1:0] coo_rows [COO_NUM_OF_COLS];
  logic [COO_BW-1:0] coo_cols [COO_NUM_OF_COLS];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_vec(input string name, input logic [VEC_W-1:0] act,
                           input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic elem_t stream_val(input int s);
    if (s < 864)      return elem_t'(s % 32);
    else if (s < 870) return elem_t'(coo_rows[s-864]);
    else              return elem_t'(coo_cols[s-870]);
  endfunction

  // Independent model: element value is its stream position mod 32.
  function automatic logic [VEC_W-1:0] exp_vec(input logic [ADDRESS_WIDTH-1:0] a);
    logic [VEC_W-1:0] v;
    int r;
    v = '0;
    if (a >= 13'd512) begin
      r = int'(a) - 512;
      if (r < 6)
        for (int i = 0; i < 96; i++) v[i*ELEM_WIDTH +: ELEM_WIDTH] = elem_t'((288 + r*96 + i) % 32);
    end else if (a < 13'd3) begin
      for (int i = 0; i < 96; i++) v[i*ELEM_WIDTH +: ELEM_WIDTH] = elem_t'((int'(a)*96 + i) % 32);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stream(input int stop_at);
    int   k = 0;
    int   budget = 0;
    logic xfer;
    while (k < stop_at && budget < 3000) begin
      i_load_valid = 1'b1;
      i_load_data  = stream_val(k);
      if (k == NTOT - 1) check_bit("mem_ready_before_last", o_mem_ready, 1'b0);
      xfer = o_load_ready;
      tick();
      budget++;
      if (xfer) k++;
    end
    i_load_valid = 1'b0;
    if (k < stop_at) check_int("load_transfers_timeout", k, stop_at);
  endtask

  task automatic run_reads(input int first, input int last);
    logic [VEC_W-1:0] e;
    for (int i = first; i <= last; i++) begin
      i_enable_read  = 1'b1;
      i_read_address = tbl[i].addr;
      sb_q.push_back(exp_vec(tbl[i].addr));
      tick();
      check_bit($sformatf("valid_%0h", tbl[i].addr), o_data_valid, 1'b1);
`ifdef MEM_RANGE_CHECK_EN
      check_bit($sformatf("addr_error_%0h", tbl[i].addr), o_addr_error, tbl[i].err);
`endif
      if (o_data_valid) begin
        if (sb_q.size() == 0) begin
          check_int("scoreboard_empty", 0, 1);
        end else begin
          e = sb_q.pop_front();
          last_exp = e;
          check_vec($sformatf("data_%0h", tbl[i].addr), dut_flat, e);
          check_vec($sformatf("d0_%0h", tbl[i].addr), VEC_W'(o_data_out[0]), VEC_W'(tbl[i].d0));
          check_vec($sformatf("d95_%0h", tbl[i].addr), VEC_W'(o_data_out[95]),
                    VEC_W'(tbl[i].d95));
        end
      end
    end
    i_enable_read = 1'b0;
    tick();
    check_bit("valid_idle", o_data_valid, 1'b0);
    check_vec("data_hold", dut_flat, last_exp);
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    coo_rows = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    coo_cols = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    tbl[0] = '{13'h003,  5'd0, 5'd0,  1'b1};
    tbl[1] = '{13'h206,  5'd0, 5'd0,  1'b1};
    tbl[2] = '{13'h1FF,  5'd0, 5'd0,  1'b1};
    tbl[3] = '{13'h1FFF, 5'd0, 5'd0,  1'b1};
    tbl[4] = '{13'h000,  5'd0, 5'd31, 1'b0};
    tbl[5] = '{13'h001,  5'd0, 5'd31, 1'b0};
    tbl[6] = '{13'h002,  5'd0, 5'd31, 1'b0};
    tbl[7] = '{13'h200,  5'd0, 5'd31, 1'b0};
    tbl[8] = '{13'h205,  5'd0, 5'd31, 1'b0};
    last_exp = '0;

    i_reset = 1'b1; i_load_valid = 1'b0; i_reload = 1'b0; i_enable_read = 1'b0;
    i_load_data = '0; i_read_address = '0; i_coo_address = '0;
    tick();
    tick();
    check_bit("rst_load_ready", o_load_ready, 1'b0);
    check_bit("rst_mem_ready", o_mem_ready, 1'b0);
    check_bit("rst_data_valid", o_data_valid, 1'b0);
    check_vec("rst_data_out", dut_flat, '0);
`ifdef MEM_RANGE_CHECK_EN
    check_bit("rst_addr_error", o_addr_error, 1'b0);
`endif
    i_reset = 1'b0;
    tick();
    check_bit("load_ready_after_rst", o_load_ready, 1'b1);
    check_bit("mem_ready_loading", o_mem_ready, 1'b0);

    // Read while loading is ignored.
    i_enable_read = 1'b1;
    i_read_address = 13'h000;
    tick();
    i_enable_read = 1'b0;
    check_bit("read_in_load_valid", o_data_valid, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
    check_bit("read_in_load_err", o_addr_error, 1'b1);
`endif

    load_stream(NTOT);
    check_bit("mem_ready_after_load", o_mem_ready, 1'b1);
    check_bit("load_ready_in_serve", o_load_ready, 1'b0);

    run_reads(0, 8);

    for (int a = 0; a < 8; a++) begin
      logic [2*COO_BW-1:0] ce;
      i_coo_address = COO_BW'(a);
      #1;
      ce = (a < 6) ? {coo_rows[a], coo_cols[a]} : '0;
      check_vec($sformatf("coo_%0d", a), VEC_W'(o_coo_out), VEC_W'(ce));
    end

    // Reset partway through a fresh load, then restream everything.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
    load_stream(100);
    i_reset = 1'b1;
    tick();
    check_bit("midload_rst_load_ready", o_load_ready, 1'b0);
    check_bit("midload_rst_valid", o_data_valid, 1'b0);
    check_vec("midload_rst_data", dut_flat, '0);
    i_reset = 1'b0;
    tick();
    load_stream(NTOT);
    check_bit("mem_ready_after_reload", o_mem_ready, 1'b1);
    run_reads(4, 6);

    // Reload wins over a simultaneous read.
    i_reload = 1'b1;
    i_enable_read = 1'b1;
    i_read_address = 13'h200;
    tick();
    i_reload = 1'b0;
    i_enable_read = 1'b0;
    check_bit("reload_valid", o_data_valid, 1'b0);
    check_bit("reload_load_ready", o_load_ready, 1'b1);
    check_bit("reload_mem_ready", o_mem_ready, 1'b0);
    check_vec("reload_data_hold", dut_flat, last_exp);
`ifdef MEM_RANGE_CHECK_EN
    check_bit("reload_addr_error", o_addr_error, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
